// File: rtl/simple_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simple_pipe_issue_ctrl
// Description : Issue and hazard controller for the simplePipe 4x8-bit
//               register datapath (NOP/ADD/SUB/AND). Accepts instructions
//               over valid/ready, sequences them through EX and WB, resolves
//               RAW hazards by forwarding or stalling, and keeps saturating
//               retire/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_pipe_issue_ctrl #(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [7:0]       inst,
  output logic             inst_ready,
  input  logic             flush,
  output logic [1:0]       rs1_addr,
  output logic [1:0]       rs2_addr,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             ex_valid,
  output logic [1:0]       ex_op,
  output logic [1:0]       ex_rd,
  output logic             wb_en,
  output logic [1:0]       wb_rd,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0]       c_op_nop  = 2'b00;
  localparam logic [1:0]       c_sel_rf  = 2'b00;
  localparam logic [1:0]       c_sel_ex  = 2'b01;
  localparam logic [1:0]       c_sel_wb  = 2'b10;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Pipeline state
  logic             ex_valid_q, ex_valid_d;
  logic [1:0]       ex_op_q, ex_op_d;
  logic [1:0]       ex_rd_q, ex_rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [1:0]       wb_op_q, wb_op_d;
  logic [1:0]       wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Instruction field decode
  logic [1:0] w_op;
  logic [1:0] w_rs1;
  logic [1:0] w_rs2;
  logic [1:0] w_rd;
  logic       w_reads;
  logic       w_ex_writes;
  logic       w_wb_en;
  logic       w_ex_m1;
  logic       w_ex_m2;
  logic       w_wb_m1;
  logic       w_wb_m2;
  logic       w_fire;

  assign w_op  = inst[7:6];
  assign w_rs1 = inst[5:4];
  assign w_rs2 = inst[3:2];
  assign w_rd  = inst[1:0];

  // NOP neither reads nor writes, so it can neither cause nor suffer a hazard.
  assign w_reads     = (w_op != c_op_nop);
  assign w_ex_writes = ex_valid_q & (ex_op_q != c_op_nop);
  // Masking with rst discards whatever sits in WB during a mid-stream reset.
  assign w_wb_en     = wb_valid_q & (wb_op_q != c_op_nop) & ~rst;

  assign w_ex_m1 = w_reads & w_ex_writes & (w_rs1 == ex_rd_q);
  assign w_ex_m2 = w_reads & w_ex_writes & (w_rs2 == ex_rd_q);
  assign w_wb_m1 = w_reads & w_wb_en & (w_rs1 == wb_rd_q);
  assign w_wb_m2 = w_reads & w_wb_en & (w_rs2 == wb_rd_q);

  assign w_fire = inst_valid & inst_ready;

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Forwarding: never stall; EX wins over WB because it is the younger writer.
      always_comb begin
        inst_ready = ~rst & ~flush;
        fwd1_sel   = c_sel_rf;
        fwd2_sel   = c_sel_rf;
        if (w_ex_m1) begin
          fwd1_sel = c_sel_ex;
        end else if (w_wb_m1) begin
          fwd1_sel = c_sel_wb;
        end
        if (w_ex_m2) begin
          fwd2_sel = c_sel_ex;
        end else if (w_wb_m2) begin
          fwd2_sel = c_sel_wb;
        end
      end
    end else begin : g_stall
      // Stalling: hold issue until every source has been committed to the regfile.
      always_comb begin
        inst_ready = ~rst & ~flush & ~(w_ex_m1 | w_ex_m2 | w_wb_m1 | w_wb_m2);
        fwd1_sel   = c_sel_rf;
        fwd2_sel   = c_sel_rf;
      end
    end
  endgenerate

  // Next-state for the EX/WB pipeline registers and the saturating counters.
  always_comb begin
    ex_valid_d   = w_fire & ~flush;
    ex_op_d      = ex_op_q;
    ex_rd_d      = ex_rd_q;
    wb_valid_d   = ex_valid_q & ~flush;
    wb_op_d      = ex_op_q;
    wb_rd_d      = ex_rd_q;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (w_fire) begin
      ex_op_d = w_op;
      ex_rd_d = w_rd;
    end
    if (wb_valid_q && (retire_cnt_q != c_cnt_max)) begin
      retire_cnt_d = retire_cnt_q + c_cnt_one;
    end
    if (inst_valid && !inst_ready && !rst && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + c_cnt_one;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= 2'b00;
      ex_rd_q      <= 2'b00;
      wb_valid_q   <= 1'b0;
      wb_op_q      <= 2'b00;
      wb_rd_q      <= 2'b00;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_op_q      <= wb_op_d;
      wb_rd_q      <= wb_rd_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rs1_addr   = w_rs1;
  assign rs2_addr   = w_rs2;
  assign ex_valid   = ex_valid_q;
  assign ex_op      = ex_op_q;
  assign ex_rd      = ex_rd_q;
  assign wb_en      = w_wb_en;
  assign wb_rd      = wb_rd_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire
